clock_set_ctrl: RTL
===================

// Module: clock_set_ctrl
// PURPOSE
//  Front-panel controller for the Millennium Clock. Reads three active-low push keys and
//  produces the view select and per-field blink enables consumed by display. It also
//  produces one-cycle increment pulses consumed by the time/date counters.
//  Sits between the board KEY pins and the display/counter blocks; it is the command source for them.
// PARAMETERS
//  DEBOUNCE_CYCLES  20     consecutive stable samples required to accept a key level change (>=2)
//  TIMEOUT_CYCLES   1000   idle cycles in a SET state before automatic return to RUN (>=2)
// PORTS
//  clk                 in   1  system clock, single domain
//  rst_n               in   1  asynchronous, active-low reset
//  key_mode            in   1  raw key, active-low, asynchronous to clk; toggles view
//  key_select          in   1  raw key, active-low; steps through set fields
//  key_inc             in   1  raw key, active-low; increments selected field
//  mode_display        out  1  1 = time view, 0 = date view
//  blink_second_year   out  1  field 0 (second/year) being set
//  blink_minute_month  out  1  field 1 (minute/month) being set
//  blink_hour_day      out  1  field 2 (hour/day) being set
//  inc_second_year     out  1  one-cycle increment pulse, field 0
//  inc_minute_month    out  1  one-cycle increment pulse, field 1
//  inc_hour_day        out  1  one-cycle increment pulse, field 2
//  set_active          out  1  1 while in any SET state (counters freeze auto-advance)
// BEHAVIOUR
//  Reset: state RUN, mode_display=1, all blink_*/inc_*/set_active=0, debounced levels=1 (released),
//   debounce and timeout counters=0. Reset mid-operation aborts SET immediately; no pulse emitted.
//  Per key: 2-FF synchroniser -> debouncer -> falling-edge detector.
//   Debouncer: counter clears whenever synced level == debounced level; otherwise counts up;
//   on reaching DEBOUNCE_CYCLES the debounced level takes the synced value and the counter clears.
//   Glitches shorter than DEBOUNCE_CYCLES never change the debounced level.
//   A press event is a registered 1-cycle pulse on debounced 1->0.
//   Latency: raw low held stable -> press event exactly DEBOUNCE_CYCLES+3 clk edges later.
//   Release (0->1) produces no event. A key held through reset release yields one press after debounce.
//  FSM states: RUN, SET_HD, SET_MM, SET_SY.
//   RUN:    select -> SET_HD; mode -> toggle mode_display; inc ignored.
//   SET_HD: select -> SET_MM; inc -> inc_hour_day pulse.
//   SET_MM: select -> SET_SY; inc -> inc_minute_month pulse.
//   SET_SY: select -> RUN;    inc -> inc_second_year pulse.
//   In any SET state, a mode press is ignored. mode_display is frozen while set_active=1.
//   Idle timeout: any SET state with no press event for TIMEOUT_CYCLES cycles -> RUN.
//  Simultaneous press events in one cycle: priority select > inc > mode. Lower-priority events that cycle are dropped.
//  Timeout counter clears on entry to SET and on every press event, and holds 0 in RUN.
//  blink_* and set_active are registered decodes of state, valid in the cycle after the transition edge.
//  inc_* asserts for exactly one cycle, in the cycle after the press event. At most one inc_* is high per cycle.
//  Holding inc gives one pulse only (no auto-repeat). Wrap/limit checking belongs to the counters.
// TESTING (bench uses DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64)
//  1 Reset, no keys -> mode_display=1, all other outputs 0 for 200 cycles.
//  2 key_mode low 3 cycles then high -> no change. Held low 20 cycles -> mode_display 1->0 once.
//    Press again -> back to 1.
//  3 select press -> blink_hour_day=1, set_active=1. Three inc presses -> exactly 3 single-cycle
//    inc_hour_day pulses, each DEBOUNCE_CYCLES+4 edges after the raw low.
//  4 select x4 from RUN -> blink sequence HD, MM, SY, then all 0 with set_active=0.
//    mode press inside SET -> mode_display unchanged.
//  5 Enter SET_MM, idle 64 cycles -> return to RUN, blink_minute_month=0. An inc press at idle
//    cycle 60 restarts the count.
//  6 select and inc raw-low on the same edge in SET_HD -> SET_MM, no inc pulse.
//    rst_n low mid-SET -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Front-panel key controller: three debounced active-low keys drive the view/set FSM.
// Press-to-effect latency is DEBOUNCE_CYCLES+4 edges; there is no backpressure and every press event is consumed.
module clock_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_mode,
    input  logic key_select,
    input  logic key_inc,
    output logic mode_display,
    output logic blink_second_year,
    output logic blink_minute_month,
    output logic blink_hour_day,
    output logic inc_second_year,
    output logic inc_minute_month,
    output logic inc_hour_day,
    output logic set_active
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RUN, SET_HD, SET_MM, SET_SY} state_t;

    // Key index: 0 = mode, 1 = select, 2 = inc.
    logic [2:0]    w_raw;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_deb;
    logic [2:0]    r_deb_d;
    logic [2:0]    r_press;
    logic [DW-1:0] r_dcnt [3];

    assign w_raw = {key_inc, key_select, key_mode};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 3'b111;
            r_sync2 <= 3'b111;
            r_deb   <= 3'b111;
            r_deb_d <= 3'b111;
            r_press <= 3'b000;
            for (int k = 0; k < 3; k++) r_dcnt[k] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            r_press <= r_deb_d & ~r_deb;
            for (int k = 0; k < 3; k++) begin
                if (r_sync2[k] == r_deb[k]) begin
                    r_dcnt[k] <= '0;
                end else if (r_dcnt[k] == DEB_LAST) begin
                    r_deb[k]  <= r_sync2[k];
                    r_dcnt[k] <= '0;
                end else begin
                    r_dcnt[k] <= r_dcnt[k] + DW'(1);
                end
            end
        end
    end

    // Same-cycle events resolve select > inc > mode; losers are discarded.
    logic w_sel;
    logic w_inc;
    logic w_mode;
    assign w_sel  = r_press[1];
    assign w_inc  = r_press[2] & ~r_press[1];
    assign w_mode = r_press[0] & ~r_press[1] & ~r_press[2];

    // Registered output decode {set_active, blink_sy, blink_mm, blink_hd}.
    function automatic logic [3:0] decode(input state_t s);
        case (s)
            SET_HD:  decode = 4'b1001;
            SET_MM:  decode = 4'b1010;
            SET_SY:  decode = 4'b1100;
            default: decode = 4'b0000;
        endcase
    endfunction

    state_t        r_state;
    logic [TW-1:0] r_to_cnt;
    logic          r_mode_display;
    logic          r_blink_hd;
    logic          r_blink_mm;
    logic          r_blink_sy;
    logic          r_set_active;
    logic          r_inc_hd;
    logic          r_inc_mm;
    logic          r_inc_sy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_to_cnt       <= '0;
            r_mode_display <= 1'b1;
            {r_set_active, r_blink_sy, r_blink_mm, r_blink_hd} <= 4'b0000;
            r_inc_hd       <= 1'b0;
            r_inc_mm       <= 1'b0;
            r_inc_sy       <= 1'b0;
        end else begin
            r_inc_hd <= 1'b0;
            r_inc_mm <= 1'b0;
            r_inc_sy <= 1'b0;
            if (r_state == RUN) begin
                r_to_cnt <= '0;
                if (w_sel) begin
                    r_state <= SET_HD;
                    {r_set_active, r_blink_sy, r_blink_mm, r_blink_hd} <= decode(SET_HD);
                end else if (w_mode) begin
                    r_mode_display <= ~r_mode_display;
                end
            end else begin
                if (|r_press) begin
                    r_to_cnt <= '0;
                end else if (r_to_cnt == TO_LAST) begin
                    r_to_cnt <= '0;
                    r_state  <= RUN;
                    {r_set_active, r_blink_sy, r_blink_mm, r_blink_hd} <= decode(RUN);
                end else begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
                if (w_sel) begin
                    case (r_state)
                        SET_HD: begin
                            r_state <= SET_MM;
                            {r_set_active, r_blink_sy, r_blink_mm, r_blink_hd} <= decode(SET_MM);
                        end
                        SET_MM: begin
                            r_state <= SET_SY;
                            {r_set_active, r_blink_sy, r_blink_mm, r_blink_hd} <= decode(SET_SY);
                        end
                        default: begin
                            r_state <= RUN;
                            {r_set_active, r_blink_sy, r_blink_mm, r_blink_hd} <= decode(RUN);
                        end
                    endcase
                end else if (w_inc) begin
                    r_inc_hd <= (r_state == SET_HD);
                    r_inc_mm <= (r_state == SET_MM);
                    r_inc_sy <= (r_state == SET_SY);
                end
            end
        end
    end

    assign mode_display       = r_mode_display;
    assign blink_hour_day     = r_blink_hd;
    assign blink_minute_month = r_blink_mm;
    assign blink_second_year  = r_blink_sy;
    assign set_active         = r_set_active;
    assign inc_hour_day       = r_inc_hd;
    assign inc_minute_month   = r_inc_mm;
    assign inc_second_year    = r_inc_sy;

endmodule
